scale_and_adjust_mc: RTL and testbench

Multi-channel successor of the single-lane gain scaler. Takes CHANNELS parallel signed samples on one AXI-Stream beat and multiplies each by its own signed fixed-point gain. Each product is rounded and saturated, not truncated. Gain changes are glitch-free: they apply atomically on a beat boundary. Full valid/ready backpressure is supported. Sits between the DSP/filter output and the DAC or stream packer on the Red Pitaya fabric.

---
 rtl/scale_adjust_pkg.sv | 21 ++
 rtl/scale_adjust_lane.sv | 68 ++++++
 rtl/scale_and_adjust_mc.sv | 116 +++++++++++
 tb/tb_scale_and_adjust_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_adjust_pkg.sv
// Shared helpers for the multi-channel scaler: saturation limits, rounding constant
// and the full-precision product width.
package scale_adjust_pkg;

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    function automatic longint round_const(input int q);
        return longint'(1) <<< (q - 1);
    endfunction

    function automatic int prod_width(input int s_width, input int g_width);
        return s_width + g_width;
    endfunction

endpackage

// File: rtl/scale_adjust_lane.sv
// One lane of the scaler: S1 sample/gain register, S2 full-width product,
// S3 round-half-up, shift and saturate. Every stage moves only when adv_i is high.
module scale_adjust_lane
    import scale_adjust_pkg::*;
#(
    parameter int S_W = 32,
    parameter int G_W = 32,
    parameter int M_W = 16,
    parameter int Q   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  adv_i,
    input  logic signed [S_W-1:0] x_i,
    input  logic signed [G_W-1:0] g_i,
    output logic signed [M_W-1:0] y_o,
    output logic                  sat_o
);
    localparam int P_W = prod_width(S_W, G_W);
    // One guard bit above the product keeps the rounding add from overflowing.
    localparam logic signed [P_W:0]   RND   = (P_W + 1)'(round_const(Q));
    localparam logic signed [P_W:0]   MAX_V = (P_W + 1)'(sat_max(M_W));
    localparam logic signed [P_W:0]   MIN_V = (P_W + 1)'(sat_min(M_W));
    localparam logic signed [M_W-1:0] Y_MAX = {1'b0, {(M_W - 1){1'b1}}};
    localparam logic signed [M_W-1:0] Y_MIN = {1'b1, {(M_W - 1){1'b0}}};

    logic signed [S_W-1:0] x1_q;
    logic signed [G_W-1:0] g1_q;
    logic signed [P_W-1:0] p2_q, p2_d;
    logic signed [M_W-1:0] y3_q, y3_d;
    logic                  sat3_q, sat3_d;
    logic signed [P_W:0]   rnd_sum, rnd_r;

    always_comb begin
        p2_d    = P_W'(x1_q) * P_W'(g1_q);
        rnd_sum = {p2_q[P_W-1], p2_q} + RND;
        rnd_r   = rnd_sum >>> Q;
        y3_d    = rnd_r[M_W-1:0];
        sat3_d  = 1'b0;
        if (rnd_r > MAX_V) begin
            y3_d   = Y_MAX;
            sat3_d = 1'b1;
        end else if (rnd_r < MIN_V) begin
            y3_d   = Y_MIN;
            sat3_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            x1_q   <= '0;
            g1_q   <= '0;
            p2_q   <= '0;
            y3_q   <= '0;
            sat3_q <= 1'b0;
        end else if (adv_i) begin
            x1_q   <= x_i;
            g1_q   <= g_i;
            p2_q   <= p2_d;
            y3_q   <= y3_d;
            sat3_q <= sat3_d;
        end
    end

    assign y_o   = y3_q;
    assign sat_o = sat3_q;

endmodule

// File: rtl/scale_and_adjust_mc.sv
// Multi-channel gain scaler over AXI-Stream with atomic per-beat gain switching.
// Optional SCALE_SAT_STATUS_EN adds sticky per-lane saturation flags (sat_flags/sat_clear).
module scale_and_adjust_mc
    import scale_adjust_pkg::*;
#(
    parameter int CHANNELS          = 2,
    parameter int S_AXIS_DATA_WIDTH = 32,
    parameter int M_AXIS_DATA_WIDTH = 16,
    parameter int GAIN_DATA_WIDTH   = 32,
    parameter int GAIN_DATA_Q       = 16
) (
    input  logic                                    a_clk,
    input  logic                                    a_resetn,
    input  logic [CHANNELS*S_AXIS_DATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic                                    S_AXIS_tvalid,
    output logic                                    S_AXIS_tready,
    input  logic [CHANNELS*GAIN_DATA_WIDTH-1:0]     gain,
    input  logic                                    gain_update,
    output logic [CHANNELS*M_AXIS_DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic                                    M_AXIS_tvalid,
    input  logic                                    M_AXIS_tready
`ifdef SCALE_SAT_STATUS_EN
    ,
    output logic [CHANNELS-1:0]                     sat_flags,
    input  logic                                    sat_clear
`endif
);
    localparam int SW = S_AXIS_DATA_WIDTH;
    localparam int GW = GAIN_DATA_WIDTH;
    localparam int MW = M_AXIS_DATA_WIDTH;
    localparam logic [GW-1:0] UNITY = GW'(1) << GAIN_DATA_Q;

    logic                   adv, accept;
    logic                   v1_q, v2_q, v3_q;
    logic [CHANNELS*GW-1:0] pend_q, pend_d, act_q, act_d, eff_gain;
    logic                   pend_flag_q, pend_flag_d;
    logic [CHANNELS-1:0]    lane_sat;

    assign adv           = !v3_q || M_AXIS_tready;
    assign accept        = S_AXIS_tvalid && adv;
    assign S_AXIS_tready = adv;
    assign M_AXIS_tvalid = v3_q;

    // A strobe coinciding with an accepted beat must already apply to that beat.
    always_comb begin
        eff_gain    = pend_flag_q ? pend_q : act_q;
        if (gain_update) eff_gain = gain;
        pend_d      = pend_q;
        act_d       = act_q;
        pend_flag_d = pend_flag_q;
        if (gain_update) begin
            pend_d      = gain;
            pend_flag_d = 1'b1;
        end
        if (accept) begin
            act_d       = eff_gain;
            pend_flag_d = 1'b0;
        end
    end

    always_ff @(posedge a_clk) begin
        if (!a_resetn) begin
            pend_q      <= {CHANNELS{UNITY}};
            act_q       <= {CHANNELS{UNITY}};
            pend_flag_q <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            act_q       <= act_d;
            pend_flag_q <= pend_flag_d;
            if (adv) begin
                v1_q <= S_AXIS_tvalid;
                v2_q <= v1_q;
                v3_q <= v2_q;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        scale_adjust_lane #(
            .S_W (SW),
            .G_W (GW),
            .M_W (MW),
            .Q   (GAIN_DATA_Q)
        ) u_lane (
            .clk_i  (a_clk),
            .rst_ni (a_resetn),
            .adv_i  (adv),
            .x_i    (S_AXIS_tdata[g*SW +: SW]),
            .g_i    (eff_gain[g*GW +: GW]),
            .y_o    (M_AXIS_tdata[g*MW +: MW]),
            .sat_o  (lane_sat[g])
        );
    end

`ifdef SCALE_SAT_STATUS_EN
    logic [CHANNELS-1:0] sat_flags_q;

    // Flags record only beats actually handed downstream; clear wins over set.
    always_ff @(posedge a_clk) begin
        if (!a_resetn || sat_clear) begin
            sat_flags_q <= '0;
        end else if (v3_q && adv) begin
            sat_flags_q <= sat_flags_q | lane_sat;
        end
    end

    assign sat_flags = sat_flags_q;
`else
    logic unused_lane_sat;
    assign unused_lane_sat = ^lane_sat;
`endif

endmodule

// File: tb/tb_scale_and_adjust_mc.sv
// Self-checking bench for scale_and_adjust_mc (CHANNELS=2, 32-bit in, 16-bit out, Q16 gains).
module tb_scale_and_adjust_mc;
  localparam logic [63:0] UNITY2 = {32'h0001_0000, 32'h0001_0000};
  localparam logic [63:0] HALF2  = {32'h0000_8000, 32'h0000_8000};
  localparam logic [63:0] TWO2   = {32'h0002_0000, 32'h0002_0000};
  localparam logic [63:0] THREE2 = {32'h0003_0000, 32'h0003_0000};

  logic        a_clk;
  logic        a_resetn;
  logic [63:0] S_AXIS_tdata;
  logic        S_AXIS_tvalid;
  logic        S_AXIS_tready;
  logic [63:0] gain;
  logic        gain_update;
  logic [31:0] M_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
`ifdef SCALE_SAT_STATUS_EN
  logic [1:0]  sat_flags;
  logic        sat_clear;
`endif

  scale_and_adjust_mc dut (
    .a_clk         (a_clk),
    .a_resetn      (a_resetn),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .gain          (gain),
    .gain_update   (gain_update),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready)
`ifdef SCALE_SAT_STATUS_EN
    ,
    .sat_flags     (sat_flags),
    .sat_clear     (sat_clear)
`endif
  );

  // clock / reset
  initial a_clk = 1'b0;
  always #5 a_clk = ~a_clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          n_out = 0;
  logic [31:0] exp_q[$];
  logic [63:0] m_act = UNITY2, m_pend = UNITY2;
  logic        m_flag = 1'b0;
  logic        stalled = 1'b0;
  logic [31:0] held_data = '0;
  logic        bp_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_lane(input logic signed [31:0] x, input logic signed [31:0] g);
    longint p, r;
    p = longint'(x) * longint'(g);
    r = (p + 64'sd32768) >>> 16;
    if (r > 64'sd32767) return 16'h7fff;
    if (r < -64'sd32768) return 16'h8000;
    return r[15:0];
  endfunction

  // scoreboard: gain model + expected queue, sampled mid-cycle
  always @(negedge a_clk) begin
    logic [63:0] eg;
    if (!a_resetn) begin
      exp_q.delete();
      m_act   = UNITY2;
      m_pend  = UNITY2;
      m_flag  = 1'b0;
      stalled = 1'b0;
    end else begin
      check("s_tready_adv", 64'(S_AXIS_tready), 64'(!M_AXIS_tvalid || M_AXIS_tready));
      if (stalled) begin
        check("stall_valid", 64'(M_AXIS_tvalid), 64'd1);
        check("stall_data", 64'(M_AXIS_tdata), 64'(held_data));
      end
      stalled   = M_AXIS_tvalid && !M_AXIS_tready;
      held_data = M_AXIS_tdata;
      if (M_AXIS_tvalid && M_AXIS_tready) begin
        n_out++;
        if (exp_q.size() == 0) check("unexpected_out", 64'(exp_q.size()), 64'd1);
        else check("out_data", 64'(M_AXIS_tdata), 64'(exp_q.pop_front()));
      end
      if (gain_update) begin
        m_pend = gain;
        m_flag = 1'b1;
      end
      if (S_AXIS_tvalid && S_AXIS_tready) begin
        eg     = m_flag ? m_pend : m_act;
        m_act  = eg;
        m_flag = 1'b0;
        exp_q.push_back({ref_lane(S_AXIS_tdata[63:32], eg[63:32]),
                         ref_lane(S_AXIS_tdata[31:0], eg[31:0])});
      end
    end
  end

  always @(posedge a_clk) begin
    if (bp_en) begin
      #1;
      M_AXIS_tready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send_beat(input logic signed [31:0] x0, input logic signed [31:0] x1);
    int   guard = 0;
    logic acc = 1'b0;
    S_AXIS_tdata  = {x1, x0};
    S_AXIS_tvalid = 1'b1;
    do begin
      @(negedge a_clk);
      acc = S_AXIS_tready;
      @(posedge a_clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
    S_AXIS_tvalid = 1'b0;
  endtask

  task automatic gain_pulse(input logic [63:0] g);
    gain        = g;
    gain_update = 1'b1;
    @(posedge a_clk);
    #1;
    gain_update = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 200) begin
      @(posedge a_clk);
      i++;
    end
    @(posedge a_clk);
    #1;
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    a_resetn      = 1'b0;
    S_AXIS_tdata  = '0;
    S_AXIS_tvalid = 1'b0;
    gain          = UNITY2;
    gain_update   = 1'b0;
    M_AXIS_tready = 1'b1;
`ifdef SCALE_SAT_STATUS_EN
    sat_clear     = 1'b0;
`endif
    repeat (3) @(posedge a_clk);
    #1;
    a_resetn = 1'b1;
    check("rst_m_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check("rst_m_tdata", 64'(M_AXIS_tdata), 64'd0);
    check("rst_s_tready", 64'(S_AXIS_tready), 64'd1);

    // unity gain and 3-cycle latency
    S_AXIS_tdata  = {-32'sd1000, 32'sd1000};
    S_AXIS_tvalid = 1'b1;
    @(posedge a_clk); #1;
    S_AXIS_tvalid = 1'b0;
    check("lat_c1", 64'(M_AXIS_tvalid), 64'd0);
    @(posedge a_clk); #1;
    check("lat_c2", 64'(M_AXIS_tvalid), 64'd0);
    @(posedge a_clk); #1;
    check("lat_c3", 64'(M_AXIS_tvalid), 64'd1);
    check("lat_data", 64'(M_AXIS_tdata), 64'h0000_0000_fc18_03e8);
    drain();

    // saturation at unity gain
    send_beat(32'sd40000, -32'sd40000);
    drain();

    // rounding at gain 0.5
    gain_pulse(HALF2);
    send_beat(32'sd3, -32'sd3);
    send_beat(32'sd1, -32'sd1);
    drain();

    // gain switch while idle, last strobe wins
    gain_pulse(UNITY2);
    send_beat(32'sd100, -32'sd7);
    send_beat(32'sd200, 32'sd9);
    send_beat(32'sd300, 32'sd11);
    gain_pulse(THREE2);
    gain_pulse(TWO2);
    send_beat(32'sd400, -32'sd13);
    drain();

    // gain strobe coincident with an accepted beat
    gain_pulse(UNITY2);
    send_beat(32'sd500, 32'sd5);
    gain        = TWO2;
    gain_update = 1'b1;
    send_beat(32'sd600, -32'sd600);
    gain_update = 1'b0;
    send_beat(32'sd700, -32'sd1);
    drain();

    // independent per-lane gains (lane0 -0.5, lane1 3.0)
    gain_pulse({32'h0003_0000, 32'hffff_8000});
    send_beat(-32'sd5, 32'sd7);
    send_beat(32'sd5, 32'sd20000);
    drain();

    // backpressure with counting data
    n_before = n_out;
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) send_beat(32'(i * 123 - 400), 32'(3 - i * 5000));
    bp_en = 1'b0;
    @(posedge a_clk); #1;
    M_AXIS_tready = 1'b1;
    drain();
    check("bp_count", 64'(n_out - n_before), 64'd10);

    // random data and gains under backpressure
    bp_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 0) gain_pulse({32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000,
                                  32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000});
      send_beat(32'($urandom_range(0, 200000)) - 32'sd100000,
                32'($urandom_range(0, 200000)) - 32'sd100000);
    end
    bp_en = 1'b0;
    @(posedge a_clk); #1;
    M_AXIS_tready = 1'b1;
    drain();

    // reset with three beats in flight
    gain_pulse(TWO2);
    M_AXIS_tready = 1'b0;
    send_beat(32'sd11, 32'sd12);
    send_beat(32'sd13, 32'sd14);
    send_beat(32'sd15, 32'sd16);
    a_resetn = 1'b0;
    @(posedge a_clk); #1;
    check("mid_rst_tvalid", 64'(M_AXIS_tvalid), 64'd0);
    check("mid_rst_tdata", 64'(M_AXIS_tdata), 64'd0);
    a_resetn      = 1'b1;
    M_AXIS_tready = 1'b1;
    n_before      = n_out;
    repeat (10) @(posedge a_clk);
    #1;
    check("no_stale_out", 64'(n_out - n_before), 64'd0);
    send_beat(32'sd1234, -32'sd1234);
    drain();
    check("post_rst_count", 64'(n_out - n_before), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
